slave_port: RTL

Serial-bus target interface that sits directly downstream of the master port on the shared serial bus, behind the address decoder. It deserialises the LSB-first memory address and write data driven on the bus, performs single-word accesses on a parallel local memory port, and serialises read data back to the master with `svalid`. An optional split mechanism releases the bus while a slow memory read is pending.

---
 rtl/slave_port.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/slave_port.sv
// Serial-bus target port: deserialises address/write data, performs single-word
// memory accesses and serialises read data back. Optional split: SLAVE_PORT_SPLIT_EN.
module slave_port #(
  parameter int ADDR_WIDTH    = 12,
  parameter int DATA_WIDTH    = 8,
  parameter int SPLIT_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  swdata,
  input  logic                  smode,
  input  logic                  mvalid,
  output logic                  srdata,
  output logic                  svalid,
  output logic                  sready,
  output logic                  ssplit,
  input  logic                  split_grant,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wen,
  output logic                  mem_ren,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid
);

  localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW   = $clog2(MAXW);
  localparam int WW   = $clog2(SPLIT_LATENCY + 1);
  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);

`ifdef SLAVE_PORT_SPLIT_EN
  typedef enum logic [2:0] {IDLE, RADDR, WDATA, MWRITE, MREAD, RSEND, SPLIT, RESUME} state_e;
  localparam logic [WW-1:0] SPLIT_AT = WW'(SPLIT_LATENCY);
`else
  typedef enum logic [2:0] {IDLE, RADDR, WDATA, MWRITE, MREAD, RSEND} state_e;
  logic unused_split_grant;
  assign unused_split_grant = split_grant;
`endif

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [WW-1:0]         wait_q, wait_d;
  logic                  mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  srdata_q, srdata_d;
  logic                  svalid_q, svalid_d;
  logic                  sready_q, sready_d;
  logic                  ssplit_q, ssplit_d;
  logic                  mem_wen_q, mem_wen_d;
  logic                  mem_ren_q, mem_ren_d;

  // Serial bits shift in from the MSB end, so after a full word the LSB-first stream is in place.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wait_d     = wait_q;
    mode_d     = mode_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    mem_addr_d = mem_addr_q;
    case (state_q)
      IDLE: if (mvalid) begin
        addr_d  = {swdata, addr_q[ADDR_WIDTH-1:1]};
        mode_d  = smode;
        cnt_d   = CW'(1);
        state_d = RADDR;
      end
      RADDR: if (mvalid) begin
        addr_d = {swdata, addr_q[ADDR_WIDTH-1:1]};
        if (cnt_q == ADDR_LAST) begin
          cnt_d      = '0;
          wait_d     = '0;
          mem_addr_d = addr_d;
          state_d    = mode_q ? WDATA : MREAD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WDATA: if (mvalid) begin
        wdata_d = {swdata, wdata_q[DATA_WIDTH-1:1]};
        if (cnt_q == DATA_LAST) begin
          cnt_d   = '0;
          state_d = MWRITE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      MWRITE: state_d = IDLE;
      MREAD: begin
        wait_d = wait_q + 1'b1;
        if (mem_rvalid) begin
          rdata_d = mem_rdata;
          cnt_d   = '0;
          state_d = RSEND;
        end
`ifdef SLAVE_PORT_SPLIT_EN
        else if (wait_d == SPLIT_AT) begin
          state_d = SPLIT;
        end
`endif
      end
      RSEND: begin
        if (cnt_q == DATA_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          rdata_d = rdata_q >> 1;
        end
      end
`ifdef SLAVE_PORT_SPLIT_EN
      SPLIT: if (mem_rvalid) begin
        rdata_d = mem_rdata;
        state_d = RESUME;
      end
      RESUME: if (split_grant) begin
        cnt_d   = '0;
        state_d = RSEND;
      end
`endif
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they appear registered in the state they belong to.
    sready_d    = (state_d == IDLE);
    svalid_d    = (state_d == RSEND);
    srdata_d    = (state_d == RSEND) ? rdata_d[0] : 1'b0;
    mem_wen_d   = (state_d == MWRITE);
    mem_wdata_d = (state_d == MWRITE) ? wdata_d : '0;
    mem_ren_d   = (state_q == RADDR) && (state_d == MREAD);
`ifdef SLAVE_PORT_SPLIT_EN
    ssplit_d    = (state_d == SPLIT);
`else
    ssplit_d    = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wait_q      <= '0;
      mode_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      srdata_q    <= 1'b0;
      svalid_q    <= 1'b0;
      sready_q    <= 1'b1;
      ssplit_q    <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_ren_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      mode_q      <= mode_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      srdata_q    <= srdata_d;
      svalid_q    <= svalid_d;
      sready_q    <= sready_d;
      ssplit_q    <= ssplit_d;
      mem_wen_q   <= mem_wen_d;
      mem_ren_q   <= mem_ren_d;
    end
  end

  assign srdata    = srdata_q;
  assign svalid    = svalid_q;
  assign sready    = sready_q;
  assign ssplit    = ssplit_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wen   = mem_wen_q;
  assign mem_ren   = mem_ren_q;

endmodule
